// File: rtl/dcp_stream_packer.sv
// dcp_stream_packer: tags the defogged RGB stream with start-of-frame and
// end-of-line markers, buffers it in a block-RAM FIFO, and re-emits it as a
// valid/ready stream that tolerates downstream stalls.
module dcp_stream_packer #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic              pixelclk,
  input  logic              reset_n,
  input  logic [23:0]       i_rgb,
  input  logic              i_data_valid,
  input  logic              i_clr_ovf,
  output logic [23:0]       o_tdata,
  output logic              o_tvalid,
  input  logic              i_tready,
  output logic              o_tuser,
  output logic              o_tlast,
  output logic              o_overflow,
  output logic [ADDR_W:0]   o_fifo_level
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0]   X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]   Y_LAST  = YW'(V_ACTIVE - 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(FIFO_DEPTH);

  // Geometry counters
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // FIFO storage; the prefetch register is the RAM's synchronous read port.
  // An entry stays counted in the level until it moves into the output
  // register, so a prefetched head still reserves its RAM slot.
  logic [25:0]       mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   level_q, level_d;
  logic              pf_vld_q, pf_vld_d;
  logic [25:0]       pf_data_q;

  // Output register
  logic        tvalid_q, tvalid_d;
  logic [23:0] tdata_q;
  logic        tuser_q, tlast_q;
  logic        ovf_q, ovf_d;

  logic        sof, eol, wr_en, drop, out_ld, rd_en;
  logic [25:0] wr_entry;

  // Tagging, FIFO handshakes and next-state values
  always_comb begin
    sof      = (x_q == '0) && (y_q == '0);
    eol      = (x_q == X_LAST);
    wr_entry = {sof, eol, i_rgb};
    // A full FIFO rejects the write even if the head leaves this cycle.
    wr_en    = i_data_valid && (level_q < DEPTH_L);
    drop     = i_data_valid && !wr_en;
    out_ld   = pf_vld_q && (!tvalid_q || i_tready);
    // Read ahead only entries written on earlier edges, so the RAM never
    // sees a read and write to the same slot on one edge.
    rd_en    = (level_q != {{ADDR_W{1'b0}}, pf_vld_q}) && (!pf_vld_q || out_ld);

    x_d = x_q;
    y_d = y_q;
    if (i_data_valid) begin
      if (eol) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    level_d = level_q;
    if (wr_en && !out_ld)      level_d = level_q + 1'b1;
    else if (!wr_en && out_ld) level_d = level_q - 1'b1;

    pf_vld_d = pf_vld_q;
    if (rd_en)       pf_vld_d = 1'b1;
    else if (out_ld) pf_vld_d = 1'b0;

    tvalid_d = tvalid_q;
    if (out_ld)        tvalid_d = 1'b1;
    else if (i_tready) tvalid_d = 1'b0;

    ovf_d = ovf_q;
    if (drop)           ovf_d = 1'b1;
    else if (i_clr_ovf) ovf_d = 1'b0;
  end

  // Control state, pointers and the output register
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      x_q      <= '0;
      y_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pf_vld_q <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      level_q  <= level_d;
      pf_vld_q <= pf_vld_d;
      tvalid_q <= tvalid_d;
      ovf_q    <= ovf_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (out_ld) begin
        tuser_q <= pf_data_q[25];
        tlast_q <= pf_data_q[24];
        tdata_q <= pf_data_q[23:0];
      end
    end
  end

  // Block-RAM write port and registered read port (no reset on storage)
  always_ff @(posedge pixelclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
    if (rd_en) pf_data_q <= mem_q[rd_ptr_q];
  end

  assign o_tdata      = tdata_q;
  assign o_tvalid     = tvalid_q;
  assign o_tuser      = tuser_q;
  assign o_tlast      = tlast_q;
  assign o_overflow   = ovf_q;
  assign o_fifo_level = level_q;

endmodule

// File: tb/tb_dcp_stream_packer.sv
// tb_dcp_stream_packer: scoreboard bench for dcp_stream_packer on a 4x2
// frame with a 4-entry FIFO.
module tb_dcp_stream_packer;

  localparam int H = 4;
  localparam int V = 2;
  localparam int D = 4;
  localparam int AW = 2;

  logic          pixelclk = 1'b0;
  logic          reset_n;
  logic [23:0]   i_rgb;
  logic          i_data_valid;
  logic          i_clr_ovf;
  logic [23:0]   o_tdata;
  logic          o_tvalid;
  logic          i_tready;
  logic          o_tuser;
  logic          o_tlast;
  logic          o_overflow;
  logic [AW:0]   o_fifo_level;

  dcp_stream_packer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D), .ADDR_W(AW)
  ) dut (
    .pixelclk(pixelclk), .reset_n(reset_n), .i_rgb(i_rgb),
    .i_data_valid(i_data_valid), .i_clr_ovf(i_clr_ovf),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .i_tready(i_tready),
    .o_tuser(o_tuser), .o_tlast(o_tlast), .o_overflow(o_overflow),
    .o_fifo_level(o_fifo_level)
  );

  always #5 pixelclk = ~pixelclk;

  logic [25:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          gx = 0;
  int          gy = 0;
  int          n_sof = 0;
  int          n_eol = 0;
  logic        prev_stall = 1'b0;
  logic [25:0] prev_beat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One pixel cycle; expected tags come from the bench's own frame position.
  task automatic px(input logic [23:0] d, input logic rdy, input logic keep, input logic clr);
    logic sof, eol;
    sof = (gx == 0) && (gy == 0);
    eol = (gx == H - 1);
    if (keep) exp_q.push_back({sof, eol, d});
    gx++;
    if (gx == H) begin
      gx = 0;
      gy++;
      if (gy == V) gy = 0;
    end
    i_data_valid = 1'b1; i_rgb = d; i_tready = rdy; i_clr_ovf = clr;
    @(posedge pixelclk); #1;
    i_data_valid = 1'b0; i_clr_ovf = 1'b0;
  endtask

  task automatic idle(input logic rdy, input logic clr);
    i_data_valid = 1'b0; i_tready = rdy; i_clr_ovf = clr;
    @(posedge pixelclk); #1;
    i_clr_ovf = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    check(name, 32'(exp_q.size()), 32'd0);
    check({name, "_tvalid"}, 32'(o_tvalid), 32'd0);
    check({name, "_level"}, 32'(o_fifo_level), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    i_data_valid = 1'b0; i_rgb = '0; i_tready = 1'b0; i_clr_ovf = 1'b0;
    exp_q.delete();
    gx = 0; gy = 0;
    @(posedge pixelclk); #1;
    @(posedge pixelclk); #1;
    reset_n = 1'b1;
    @(posedge pixelclk); #1;
  endtask

  // Monitor: pops the scoreboard on each handshake and checks stall stability
  always @(negedge pixelclk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && o_tvalid)
        check("stall_hold", 32'({o_tuser, o_tlast, o_tdata}), 32'(prev_beat));
      if (o_tvalid && i_tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL beat: got %h, expected no beat", {o_tuser, o_tlast, o_tdata});
        end else begin
          check("beat", 32'({o_tuser, o_tlast, o_tdata}), 32'(exp_q.pop_front()));
        end
        if (o_tuser) n_sof++;
        if (o_tlast) n_eol++;
      end
      prev_stall = o_tvalid && !i_tready;
      prev_beat  = {o_tuser, o_tlast, o_tdata};
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    reset_n = 1'b0;
    i_data_valid = 1'b0; i_rgb = '0; i_tready = 1'b0; i_clr_ovf = 1'b0;
    #3;
    check("rst_tvalid", 32'(o_tvalid), 32'd0);
    check("rst_tdata", 32'(o_tdata), 32'd0);
    check("rst_tuser", 32'(o_tuser), 32'd0);
    check("rst_tlast", 32'(o_tlast), 32'd0);
    check("rst_ovf", 32'(o_overflow), 32'd0);
    check("rst_level", 32'(o_fifo_level), 32'd0);
    @(posedge pixelclk); #1;
    reset_n = 1'b1;
    @(posedge pixelclk); #1;

    // 4x2 frame at full rate: latency of two edges, no bubbles
    for (int i = 1; i <= 8; i++) begin
      px(24'(i), 1'b1, 1'b1, 1'b0);
      if (i <= 2) check("lat_early_tvalid", 32'(o_tvalid), 32'd0);
      if (i == 3) begin
        check("lat_tdata", 32'(o_tdata), 32'h000001);
        check("lat_tuser", 32'(o_tuser), 32'd1);
      end
      if (i >= 3) check("no_bubble", 32'(o_tvalid), 32'd1);
    end
    drain("t1_drain");

    // Same frame with a 1,0,0,1 ready pattern and pixels every other cycle
    for (int c = 0; c < 16; c++) begin
      logic rdy;
      rdy = (c % 4 == 0) || (c % 4 == 3);
      if (c % 2 == 0) px(24'(c / 2 + 1), rdy, 1'b1, 1'b0);
      else idle(rdy, 1'b0);
    end
    drain("t2_drain");
    check("t2_ovf", 32'(o_overflow), 32'd0);

    // Overflow: six pixels into a stalled path, the sixth is lost
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      px(24'h0C0000 + 24'(i), 1'b0, (i <= 5), 1'b0);
      if (i == 5) begin
        check("t3_level5", 32'(o_fifo_level), 32'd4);
        check("t3_ovf5", 32'(o_overflow), 32'd0);
      end
    end
    check("t3_level_full", 32'(o_fifo_level), 32'd4);
    check("t3_ovf", 32'(o_overflow), 32'd1);
    drain("t3_drain");
    px(24'h0C0007, 1'b1, 1'b1, 1'b0);
    px(24'h0C0008, 1'b1, 1'b1, 1'b0);
    px(24'h0D0001, 1'b1, 1'b1, 1'b0);
    drain("t3_next_frame");
    check("t3_ovf_sticky", 32'(o_overflow), 32'd1);

    // Overflow clear, and a drop coinciding with a clear keeps it set
    idle(1'b1, 1'b1);
    check("t4_clr", 32'(o_overflow), 32'd0);
    for (int i = 1; i <= 6; i++) px(24'h0E0000 + 24'(i), 1'b0, (i <= 5), 1'b0);
    check("t4_ovf_set", 32'(o_overflow), 32'd1);
    px(24'h0E0007, 1'b0, 1'b0, 1'b1);
    check("t4_set_wins", 32'(o_overflow), 32'd1);
    check("t4_level", 32'(o_fifo_level), 32'd4);
    idle(1'b0, 1'b1);
    check("t4_clr2", 32'(o_overflow), 32'd0);
    drain("t4_drain");

    // Mid-line reset with buffered pixels
    do_reset();
    px(24'h0A0001, 1'b0, 1'b1, 1'b0);
    px(24'h0A0002, 1'b0, 1'b1, 1'b0);
    px(24'h0A0003, 1'b0, 1'b1, 1'b0);
    check("t5_pre_tvalid", 32'(o_tvalid), 32'd1);
    check("t5_pre_level", 32'(o_fifo_level), 32'd2);
    reset_n = 1'b0;
    #2;
    check("t5_tvalid", 32'(o_tvalid), 32'd0);
    check("t5_tdata", 32'(o_tdata), 32'd0);
    check("t5_tuser", 32'(o_tuser), 32'd0);
    check("t5_tlast", 32'(o_tlast), 32'd0);
    check("t5_level", 32'(o_fifo_level), 32'd0);
    exp_q.delete();
    gx = 0; gy = 0;
    @(posedge pixelclk); #1;
    reset_n = 1'b1;
    @(posedge pixelclk); #1;
    px(24'h0B0001, 1'b1, 1'b1, 1'b0);
    drain("t5_drain");

    // Three back-to-back frames at full rate
    do_reset();
    n_sof = 0; n_eol = 0;
    for (int i = 0; i < 3 * H * V; i++) begin
      px(24'h100000 + 24'(i), 1'b1, 1'b1, 1'b0);
      if (i >= 2) check("t6_no_bubble", 32'(o_tvalid), 32'd1);
    end
    drain("t6_drain");
    check("t6_sof_count", 32'(n_sof), 32'd3);
    check("t6_eol_count", 32'(n_eol), 32'd6);
    check("t6_ovf", 32'(o_overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dcp_stream_packer.md
Name: dcp_stream_packer

Overview:
- Sits directly downstream of the dehaze (defog) pipeline.
- Consumes the valid-qualified 24-bit defogged RGB pixel stream, which has no backpressure.
- Tags each pixel with start-of-frame and end-of-line markers from parameterised frame geometry.
- Buffers pixels in a FIFO and presents them on a valid/ready output stream (tdata/tuser/tlast) for a VDMA or HDMI output stage that may stall.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- FIFO_DEPTH, 1024, FIFO entries; must be a power of two and at least 4.
- ADDR_W, 10, log2(FIFO_DEPTH).

Ports:
- pixelclk  input  1  pixel clock; all logic on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_rgb  input  24  defogged pixel {R[23:16], G[15:8], B[7:0]}.
- i_data_valid  input  1  i_rgb valid this cycle; no backpressure possible.
- i_clr_ovf  input  1  synchronous pulse that clears o_overflow.
- o_tdata  output  24  output pixel.
- o_tvalid  output  1  output beat valid.
- i_tready  input  1  downstream accepts the beat.
- o_tuser  output  1  first pixel of frame (x=0, y=0).
- o_tlast  output  1  last pixel of line (x=H_ACTIVE-1).
- o_overflow  output  1  sticky: at least one pixel dropped because the FIFO was full.
- o_fifo_level  output  ADDR_W+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - x and y counters are 0; FIFO is empty (pointers 0, level 0).
  - o_tvalid, o_tdata, o_tuser, o_tlast and o_overflow are all 0.
  - Reset asserted mid-frame discards all buffered data; after release, the next i_data_valid pixel is treated as x=0, y=0.
- Geometry counters:
  - Advance only on i_data_valid=1.
  - x increments; at x=H_ACTIVE-1, x wraps to 0 and y increments.
  - At x=H_ACTIVE-1 with y=V_ACTIVE-1, both wrap to 0.
  - Counters advance even when the pixel is dropped, so geometry never slips.
- Tagging:
  - sof = (x==0 && y==0); eol = (x==H_ACTIVE-1).
  - Each FIFO entry is 26 bits: {sof, eol, rgb}.
- Write side:
  - Write when i_data_valid=1 and level < FIFO_DEPTH.
  - When full, the write is rejected even if a pop occurs in the same cycle. The pixel is dropped and o_overflow is set on the next edge.
- o_overflow:
  - Stays set until i_clr_ovf=1.
  - If i_clr_ovf and a new drop coincide, set wins.
- Read side:
  - Synchronous-read RAM (block-RAM inferable) feeding one output register; the output register is not counted in o_fifo_level.
  - Output register loads when FIFO is non-empty and (o_tvalid=0 or i_tready=1).
  - o_tvalid clears after a handshake when no new entry is available.
  - A prefetch stage may be used between RAM and output register, provided the latency and stall rules below hold.
- Latency: with FIFO empty and i_tready=1, a pixel sampled with i_data_valid at edge k gives o_tvalid=1 with that pixel after edge k+2.
- Stall hold: while o_tvalid=1 and i_tready=0, o_tdata, o_tuser and o_tlast hold stable.
- Throughput: with i_tready held at 1, sustains one beat per cycle with no bubbles in steady state.
- Level and pointers:
  - o_fifo_level = writes − pops, updated each edge; simultaneous push and pop leaves it unchanged.
  - Pointers are ADDR_W bits and wrap modulo FIFO_DEPTH.
- Ordering: output order equals input order; no reordering or duplication.

Test Plan:
- Reset then a 4x2 frame (H_ACTIVE=4, V_ACTIVE=2), pixels 0x000001..0x000008, i_tready=1 → 8 beats in order. tuser only on 0x000001; tlast on 0x000004 and 0x000008; first o_tvalid two edges after the first input.
- Same frame with i_tready toggling 1,0,0,1 repeatedly → no loss or duplication, data stable during every stall, o_fifo_level returns to 0.
- FIFO_DEPTH=4, i_tready=0, 6 consecutive pixels → o_fifo_level=4 and o_overflow=1. Then i_tready=1 → exactly the first 5 pixels emerge (4 from the FIFO plus 1 in the output register) and the 6th is lost. Counters still place the next frame's first pixel with tuser=1.
- o_overflow set, then i_clr_ovf pulse → cleared next edge. i_clr_ovf asserted in the same cycle as a new drop → o_overflow stays 1.
- reset_n low mid-line (x=2) with 3 pixels buffered → all outputs 0 immediately. After release, the next pixel carries tuser=1.
- Two back-to-back 640x480 frames with continuous valid and i_tready=1 → 307200 beats per frame, tuser once per frame, tlast every 640 beats, o_overflow=0.
